// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and classify a push-button into level and event pulses
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click_pulse,
  output logic long_press_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic IDLE_PIN = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
  typedef enum logic [1:0] {RELEASED, PRESSED, LONG_HELD} state_t;
  state_t state;
  logic s1, s2, s, db_done, rise, fall, hold_max;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  assign s = s2 ^ IDLE_PIN;
  assign db_done = (s != btn_level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rise = db_done & s;
  assign fall = db_done & ~s;
  assign hold_max = hold_cnt == HW'(LONG_PRESS_CYCLES - 1);
  // two-flop synchroniser, idling at the released pin level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2} <= {IDLE_PIN, IDLE_PIN};
    else {s1, s2} <= {btn, s1};
  // debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db_cnt <= '0;
      btn_level <= 1'b0;
    end else begin
      db_cnt <= (s == btn_level || db_done) ? '0 : db_cnt + DW'(1);
      btn_level <= btn_level ^ db_done;
    end
  // hold FSM with registered event pulses; a release on the threshold edge counts as a short click
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RELEASED;
      hold_cnt <= '0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      short_click_pulse <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      press_pulse <= rise;
      release_pulse <= fall;
      short_click_pulse <= fall && state == PRESSED;
      long_press_pulse <= !fall && state == PRESSED && hold_max;
      case (state)
        RELEASED: if (rise) begin
          state <= PRESSED;
          hold_cnt <= '0;
        end
        PRESSED: if (fall) state <= RELEASED;
          else if (hold_max) state <= LONG_HELD;
          else hold_cnt <= hold_cnt + HW'(1);
        default: if (fall) state <= RELEASED;
      endcase
    end
endmodule
